// File: rtl/seq_cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: slice width and FSM states.
package seq_cla_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_cla_adder_cla_4.sv
// cla_4: 4-bit carry-lookahead slice with group generate/propagate outputs.
module cla_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       g_out,
  output logic       p_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c[0]  = c_in;
    c[1]  = g[0] | (p[0] & c_in);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c;
    g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    p_out = &p;
  end

endmodule

// File: rtl/seq_cla_adder.sv
// seq_cla_adder: WIDTH-bit adder, one nibble per clock through a single cla_4 slice.
// Define SEQ_CLA_SUB_EN to add the sub port (a - b via inverted B and carry-in of 1).
module seq_cla_adder
  import seq_cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SEQ_CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NNIB = WIDTH / NIB;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, b_eff, sum_next;
  logic             carry, carry_next, c_first;
  logic [CW-1:0]    cnt;
  logic             sa, sb;
  logic [NIB-1:0]   slice_sum;
  logic             grp_g, grp_p;
  logic             accept, last;

  always_comb begin
`ifdef SEQ_CLA_SUB_EN
    b_eff   = sub ? ~b : b;
    c_first = sub ? 1'b1 : c_in;
`else
    b_eff   = b;
    c_first = c_in;
`endif
  end

  assign accept     = in_valid && in_ready;
  assign last       = (state == RUN) && (cnt == LAST);
  assign carry_next = grp_g | (grp_p & carry);

  cla_4 u_slice (
    .a    (a_sh[NIB-1:0]),
    .b    (b_sh[NIB-1:0]),
    .c_in (carry),
    .sum  (slice_sum),
    .g_out(grp_g),
    .p_out(grp_p)
  );

  // Partial sums enter at the top and migrate down, so after the last nibble the
  // concatenation is the full LSB-aligned result.
  if (WIDTH > NIB) begin : g_wide
    logic [WIDTH-NIB-1:0] sum_sh;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             sum_sh <= '0;
      else if (state == RUN)  sum_sh <= sum_next[WIDTH-1:NIB];
    end
    assign sum_next = {slice_sum, sum_sh};
  end else begin : g_narrow
    assign sum_next = slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN:  if (cnt == LAST) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_eff;
      carry <= c_first;
      cnt   <= '0;
      sa    <= a[WIDTH-1];
      sb    <= b_eff[WIDTH-1];
    end else if (state == RUN) begin
      a_sh  <= a_sh >> NIB;
      b_sh  <= b_sh >> NIB;
      carry <= carry_next;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum   <= sum_next;
        c_out <= carry_next;
        ovf   <= (sa == sb) && (sum_next[WIDTH-1] != sa);
      end
    end
  end

endmodule

// File: tb/tb_seq_cla_adder.sv
// Scoreboard bench for seq_cla_adder (WIDTH=16); covers the sub path when SEQ_CLA_SUB_EN is defined.
module tb_seq_cla_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  seq_cla_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef SEQ_CLA_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  // Drive one accept edge and record the reference result.
  task automatic issue_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic s);
    logic [W:0]   r;
    logic [W-1:0] be;
    logic         c0;
    exp_t         e;
    be = s ? ~bv : bv;
    c0 = s ? 1'b1 : ci;
    r  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c0};
    e.sum   = r[W-1:0];
    e.c_out = r[W];
    e.ovf   = (av[W-1] == be[W-1]) && (r[W-1] != av[W-1]);
    sb_q.push_back(e);
    a = av; b = bv; c_in = ci; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, sum, c_out, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, sum, c_out, ovf});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_add;
    logic [W-1:0] va[4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] vb[4] = '{16'h4321, 16'h0001, 16'h0001, 16'h8000};
    logic         vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_t         e;
    int           lat;
    for (int i = 0; i < 4; i++) begin
      issue_op(va[i], vb[i], vc[i], 1'b0);
      wait_out(lat);
      total++;
      if (lat != 4) begin
        bad++;
        $display("FAIL add_latency[%0d] got=%0d exp=4", i, lat);
      end
      e = sb_q.pop_front();
      total++;
      if ({sum, c_out, ovf} !== {e.sum, e.c_out, e.ovf}) begin
        bad++;
        $display("FAIL add_result[%0d] got=%h/%b/%b exp=%h/%b/%b",
                 i, sum, c_out, ovf, e.sum, e.c_out, e.ovf);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL add_release[%0d] got=%b%b exp=10", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_hold;
    exp_t e;
    int   lat;
    int   seen;
    issue_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_ready_run got=%b exp=0", in_ready);
    end
    wait_out(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL hold_latency got=%0d exp=4", lat);
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.sum ||
          c_out !== e.c_out || ovf !== e.ovf) begin
        bad++;
        $display("FAIL hold_stable[%0d] got=%b%b/%h exp=10/%h",
                 i, out_valid, in_ready, sum, e.sum);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== e.sum) begin
      bad++;
      $display("FAIL hold_release got=%b%b/%h exp=10/%h", in_ready, out_valid, sum, e.sum);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL hold_no_second_op got=%0d exp=0", seen);
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   lat;
    int   seen;
    issue_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, sum, c_out, ovf} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got=%h exp=0", {out_valid, sum, c_out, ovf});
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_no_valid got=%0d exp=0", seen);
    end
    void'(sb_q.pop_back());
    issue_op(16'h0009, 16'h0006, 1'b0, 1'b0);
    wait_out(lat);
    e = sb_q.pop_front();
    total++;
    if (lat != 4 || sum !== e.sum || sum !== 16'h000F || c_out !== e.c_out) begin
      bad++;
      $display("FAIL abort_fresh got=%h/%0d exp=%h/4", sum, lat, e.sum);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef SEQ_CLA_SUB_EN
  task automatic test_sub;
    logic [W-1:0] va[2] = '{16'h0005, 16'h8000};
    logic [W-1:0] vb[2] = '{16'h0007, 16'h0001};
    exp_t         e;
    int           lat;
    for (int i = 0; i < 2; i++) begin
      issue_op(va[i], vb[i], 1'b0, 1'b1);
      wait_out(lat);
      e = sb_q.pop_front();
      total++;
      if (lat != 4 || {sum, c_out, ovf} !== {e.sum, e.c_out, e.ovf}) begin
        bad++;
        $display("FAIL sub_result[%0d] got=%h/%b/%b/%0d exp=%h/%b/%b/4",
                 i, sum, c_out, ovf, lat, e.sum, e.c_out, e.ovf);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_hold;
    test_reset_abort;
`ifdef SEQ_CLA_SUB_EN
    test_sub;
`endif
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
